btn_step_conditioner: RTL and testbench

Conditions the four raw board push-buttons (east, west, north, south) for the cursor-position stage. Each button is synchronised and debounced, and the block emits a single-cycle step strobe on each press, with optional auto-repeat while a button is held. It sits directly upstream of the cursor-position counter: the debounced levels drive that stage's button inputs, and step_out drives its update strobe in place of a free-running slow clock.

---
 rtl/btn_pkg.sv | 9 +
 rtl/btn_step_conditioner_if.sv | 13 +
 rtl/btn_debounce.sv | 36 +++
 rtl/btn_step_conditioner.sv | 87 ++++++++
 tb/tb_btn_step_conditioner.sv | 162 ++++++++++++++++
 5 files changed

// File: rtl/btn_pkg.sv
// btn_pkg: shared FSM states, direction codes and the direction priority encoder
// used by btn_step_conditioner.
package btn_pkg;
    typedef enum logic [1:0] {IDLE, DELAY, REPEAT} state_t;
    typedef enum logic [2:0] {NONE, EAST, WEST, NORTH, SOUTH} dir_t;
    function automatic dir_t prio_dir(input logic e, input logic w, input logic n, input logic s);
        return e ? EAST : w ? WEST : n ? NORTH : s ? SOUTH : NONE;
    endfunction
endpackage

// File: rtl/btn_step_conditioner_if.sv
// btn_step_conditioner_if: raw button inputs and conditioned outputs of btn_step_conditioner.
interface btn_step_conditioner_if;
    logic BTN_EAST, BTN_WEST, BTN_NORTH, BTN_SOUTH;
    logic btn_east_out, btn_west_out, btn_north_out, btn_south_out, step_out;
    modport master (
        output BTN_EAST, BTN_WEST, BTN_NORTH, BTN_SOUTH,
        input  btn_east_out, btn_west_out, btn_north_out, btn_south_out, step_out
    );
    modport slave (
        input  BTN_EAST, BTN_WEST, BTN_NORTH, BTN_SOUTH,
        output btn_east_out, btn_west_out, btn_north_out, btn_south_out, step_out
    );
endinterface

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchroniser plus debounce counter for one raw button;
// the level flips after DEBOUNCE_CYCLES consecutive cycles of disagreement.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic i_raw,
    output logic o_level
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    logic [1:0]    r_sync;
    logic [CW-1:0] r_cnt;
    logic          r_level;
    if (DEBOUNCE_CYCLES < 2) begin : g_bad_param
        $error("DEBOUNCE_CYCLES must be at least 2");
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
        end else begin
            r_sync <= {r_sync[0], i_raw};
            if (r_sync[1] == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_level <= ~r_level;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end
    assign o_level = r_level;
endmodule

// File: rtl/btn_step_conditioner.sv
// btn_step_conditioner: debounces four buttons and emits a one-cycle step strobe per press,
// with auto-repeat while held when BTN_AUTOREPEAT_EN is defined.
module btn_step_conditioner
    import btn_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 2500000
) (
    input logic               clk_in,
    input logic               rst_in,
    btn_step_conditioner_if.slave bus
);
    logic [3:0] w_raw, w_lvl;
    dir_t       w_dir, r_dir;
    state_t     r_state, w_state;
    logic       r_step, w_step;
    if (REPEAT_DELAY < 2 || REPEAT_PERIOD < 2) begin : g_bad_param
        $error("REPEAT_DELAY and REPEAT_PERIOD must be at least 2");
    end
    assign w_raw = {bus.BTN_EAST, bus.BTN_WEST, bus.BTN_NORTH, bus.BTN_SOUTH};
    for (genvar g = 0; g < 4; g++) begin : g_db
        btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
            .clk_in (clk_in),
            .rst_in (rst_in),
            .i_raw  (w_raw[g]),
            .o_level(w_lvl[g])
        );
    end
    assign {bus.btn_east_out, bus.btn_west_out, bus.btn_north_out, bus.btn_south_out} = w_lvl;
    assign bus.step_out = r_step;
    assign w_dir = prio_dir(w_lvl[3], w_lvl[2], w_lvl[1], w_lvl[0]);
`ifdef BTN_AUTOREPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX);
    logic [RW-1:0] r_cnt, w_cnt;
    logic          w_hit;
    assign w_hit = (r_state == DELAY) ? (r_cnt == RW'(REPEAT_DELAY - 1))
                                      : (r_cnt == RW'(REPEAT_PERIOD - 1));
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_step  = 1'b0;
        if (w_dir == NONE) begin
            w_state = IDLE;
            w_cnt   = '0;
        end else if (r_state == IDLE || w_dir != r_dir) begin
            w_step  = 1'b1;
            w_cnt   = '0;
            w_state = DELAY;
        end else if (w_hit) begin
            w_step  = 1'b1;
            w_cnt   = '0;
            w_state = REPEAT;
        end else begin
            w_cnt = r_cnt + RW'(1);
        end
    end
    always_ff @(posedge clk_in) begin
        if (rst_in) r_cnt <= '0;
        else        r_cnt <= w_cnt;
    end
`else
    // Without auto-repeat the FSM parks in DELAY until release or a direction change.
    always_comb begin
        w_state = r_state;
        w_step  = 1'b0;
        if (w_dir == NONE) begin
            w_state = IDLE;
        end else if (r_state == IDLE || w_dir != r_dir) begin
            w_step  = 1'b1;
            w_state = DELAY;
        end
    end
`endif
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= IDLE;
            r_dir   <= NONE;
            r_step  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_dir   <= w_dir;
            r_step  <= w_step;
        end
    end
endmodule

// File: tb/tb_btn_step_conditioner.sv
// tb_btn_step_conditioner: table-driven and random checks of btn_step_conditioner
// against a cycle-level behavioural model of debounce and step rules.
module tb_btn_step_conditioner;
    localparam int DC = 4, RD = 10, RP = 3;
`ifdef BTN_AUTOREPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif
    typedef struct {
        bit         rst;
        logic [3:0] btn;
        int         cycles;
        int         steps;
        logic [3:0] lvl;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] btn = 4'b0000;
    logic [3:0] lvl;
    logic       step;
    int         n_cmp = 0, n_bad = 0, seg_steps = 0;

    logic [3:0] m_s1, m_s2, m_deb;
    int         m_run[4];
    int         m_prev, m_elapsed, m_reps;
    logic       m_step;

    always #5 clk = ~clk;

    btn_step_conditioner_if bif ();
    btn_step_conditioner #(
        .DEBOUNCE_CYCLES(DC), .REPEAT_DELAY(RD), .REPEAT_PERIOD(RP)
    ) dut (
        .clk_in(clk), .rst_in(rst), .bus(bif)
    );
    assign {bif.BTN_EAST, bif.BTN_WEST, bif.BTN_NORTH, bif.BTN_SOUTH} = btn;
    assign lvl  = {bif.btn_east_out, bif.btn_west_out, bif.btn_north_out, bif.btn_south_out};
    assign step = bif.step_out;

    function automatic int dir_of(input logic [3:0] l);
        if (l[3]) return 1;
        if (l[2]) return 2;
        if (l[1]) return 3;
        if (l[0]) return 4;
        return 0;
    endfunction

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Step decision uses the debounced levels seen before the edge, then levels advance.
    task automatic model_edge();
        int   d;
        logic f;
        if (rst) begin
            m_s1 = '0; m_s2 = '0; m_deb = '0; m_run = '{default: 0};
            m_prev = 0; m_elapsed = 0; m_reps = 0; m_step = 1'b0;
        end else begin
            d = dir_of(m_deb);
            f = (d != 0) && ((d != m_prev) ||
                (AR && (m_elapsed + 1 == ((m_reps == 0) ? RD : RP))));
            if (f) begin
                m_reps    = (d != m_prev) ? 0 : m_reps + 1;
                m_elapsed = 0;
            end else begin
                m_elapsed++;
            end
            if (d == 0) m_reps = 0;
            m_prev = d;
            m_step = f;
            for (int b = 0; b < 4; b++) begin
                if (m_s2[b] != m_deb[b]) begin
                    m_run[b]++;
                    if (m_run[b] == DC) begin
                        m_deb[b] = ~m_deb[b];
                        m_run[b] = 0;
                    end
                end else begin
                    m_run[b] = 0;
                end
            end
            m_s2 = m_s1;
            m_s1 = btn;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("cycle", {lvl, step}, {m_deb, m_step});
        if (step) seg_steps++;
    endtask

    initial begin
        vec_t vt[$];
        int   t;
        vt.push_back('{1'b1, 4'b1000, 5, 0, 4'b0000});
        vt.push_back('{1'b0, 4'b1000, 7, 1, 4'b1000});
        vt.push_back('{1'b0, 4'b0000, 6, 0, 4'b0000});
        vt.push_back('{1'b0, 4'b0000, 4, 0, 4'b0000});
        vt.push_back('{1'b0, 4'b0010, 3, 0, 4'b0000});
        vt.push_back('{1'b0, 4'b0000, 3, 0, 4'b0000});
        vt.push_back('{1'b0, 4'b0010, 3, 0, 4'b0000});
        vt.push_back('{1'b0, 4'b0000, 3, 0, 4'b0000});
        vt.push_back('{1'b0, 4'b0001, 40, AR ? 9 : 1, 4'b0001});
        vt.push_back('{1'b0, 4'b0000, 12, AR ? 2 : 0, 4'b0000});
        vt.push_back('{1'b0, 4'b0100, 9, 1, 4'b0100});
        vt.push_back('{1'b0, 4'b1100, 20, AR ? 3 : 1, 4'b1100});
        vt.push_back('{1'b0, 4'b0000, 10, AR ? 2 : 0, 4'b0000});
        vt.push_back('{1'b0, 4'b1000, 25, AR ? 4 : 1, 4'b1000});
        vt.push_back('{1'b1, 4'b1000, 1, 0, 4'b0000});
        vt.push_back('{1'b0, 4'b1000, 7, 1, 4'b1000});
        vt.push_back('{1'b0, 4'b0000, 12, 0, 4'b0000});

        for (int v = 0; v < vt.size(); v++) begin
            rst = vt[v].rst;
            btn = vt[v].btn;
            seg_steps = 0;
            for (int c = 0; c < vt[v].cycles; c++) cycle();
            check($sformatf("vec%0d_steps", v), seg_steps, vt[v].steps);
            check($sformatf("vec%0d_levels", v), lvl, vt[v].lvl);
        end

        // Button held through reset: step must arrive exactly 7 cycles after release, 1 cycle wide.
        rst = 1'b1;
        btn = 4'b0001;
        cycle();
        cycle();
        check("held_reset_step", step, 0);
        rst = 1'b0;
        t = -1;
        for (int i = 1; i <= 20 && t < 0; i++) begin
            cycle();
            if (step) t = i;
        end
        check("press_latency", t, 7);
        cycle();
        check("pulse_width", step, 0);

        for (int r = 0; r < 60; r++) begin
            int len;
            rst = ($urandom_range(0, 29) == 0);
            btn = 4'($urandom_range(0, 15));
            len = rst ? 1 : $urandom_range(1, 14);
            for (int c = 0; c < len; c++) cycle();
        end
        rst = 1'b0;
        btn = 4'b0000;
        for (int c = 0; c < 15; c++) cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
